// File: rtl/vga_anim_sequencer.sv
// Per-frame animation controller: turns vsync into a frame strobe and steps the
// scroll offset, circle radius (GROW/HOLD/SHRINK/PAUSE) and palette on each update.
module vga_anim_sequencer #(
  parameter int VSYNC_ACTIVE_LOW = 1,
  parameter int RADIUS_MIN       = 40,
  parameter int RADIUS_MAX       = 200,
  parameter int RADIUS_STEP      = 2,
  parameter int HOLD_FRAMES      = 60,
  parameter int PAUSE_FRAMES     = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pause,
  input  logic       step,
  input  logic [1:0] speed,
  output logic [9:0] scroll,
  output logic [9:0] radius,
  output logic [1:0] phase,
  output logic [1:0] palette,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    GROW   = 2'd0,
    HOLD   = 2'd1,
    SHRINK = 2'd2,
    PAUSE  = 2'd3
  } phase_e;

  localparam logic        VS_INV     = (VSYNC_ACTIVE_LOW != 0);
  localparam logic [9:0]  R_MIN      = 10'(RADIUS_MIN);
  localparam logic [9:0]  R_MAX      = 10'(RADIUS_MAX);
  localparam logic [9:0]  R_STEP     = 10'(RADIUS_STEP);
  localparam logic [10:0] R_MAX_W    = 11'(RADIUS_MAX);
  localparam logic [10:0] R_LOW_W    = 11'(RADIUS_MIN + RADIUS_STEP);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0]  PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

  logic        vs_act, ev, st_ev, div_term, upd;
  logic [3:0]  div_lim;
  logic [10:0] grow_sum;
  logic        vs_d1_q, step_d1_q, frame_tick_q;
  logic [2:0]  div_q, div_d;
  logic [9:0]  scroll_q, scroll_d, radius_q, radius_d;
  phase_e      phase_q, phase_d;
  logic [1:0]  pal_q, pal_d;
  logic [7:0]  dwell_q, dwell_d;

  assign vs_act   = vsync ^ VS_INV;
  assign ev       = vs_act & ~vs_d1_q;
  assign st_ev    = step & ~step_d1_q;
  // >= rather than == so lowering speed mid-count fires on the next frame
  assign div_lim  = (4'd1 << speed) - 4'd1;
  assign div_term = ({1'b0, div_q} >= div_lim);
  assign upd      = (ev & ~pause & div_term) | (st_ev & pause);
  assign grow_sum = {1'b0, radius_q} + {1'b0, R_STEP};

  always_comb begin
    div_d    = div_q;
    scroll_d = scroll_q;
    radius_d = radius_q;
    phase_d  = phase_q;
    pal_d    = pal_q;
    dwell_d  = dwell_q;
    if (ev && !pause) begin
      div_d = div_term ? 3'd0 : div_q + 3'd1;
    end
    if (upd) begin
      scroll_d = scroll_q + 10'd1;
      unique case (phase_q)
        GROW: begin
          if (grow_sum >= R_MAX_W) begin
            radius_d = R_MAX;
            phase_d  = HOLD;
            dwell_d  = 8'd0;
          end else begin
            radius_d = grow_sum[9:0];
          end
        end
        HOLD: begin
          if (dwell_q == HOLD_LAST) begin
            phase_d = SHRINK;
            dwell_d = 8'd0;
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end
        // compare before subtracting so the radius can never underflow
        SHRINK: begin
          if ({1'b0, radius_q} <= R_LOW_W) begin
            radius_d = R_MIN;
            phase_d  = PAUSE;
            dwell_d  = 8'd0;
          end else begin
            radius_d = radius_q - R_STEP;
          end
        end
        PAUSE: begin
          if (dwell_q == PAUSE_LAST) begin
            phase_d = GROW;
            dwell_d = 8'd0;
            pal_d   = pal_q + 2'd1;
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end
        default: phase_d = GROW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1_q      <= 1'b0;
      step_d1_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      div_q        <= 3'd0;
      scroll_q     <= 10'd0;
      radius_q     <= R_MIN;
      phase_q      <= GROW;
      pal_q        <= 2'd0;
      dwell_q      <= 8'd0;
    end else begin
      vs_d1_q      <= vs_act;
      step_d1_q    <= step;
      frame_tick_q <= ev;
      div_q        <= div_d;
      scroll_q     <= scroll_d;
      radius_q     <= radius_d;
      phase_q      <= phase_d;
      pal_q        <= pal_d;
      dwell_q      <= dwell_d;
    end
  end

  assign scroll     = scroll_q;
  assign radius     = radius_q;
  assign phase      = phase_q;
  assign palette    = pal_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_anim_sequencer.sv
// Bench for vga_anim_sequencer: a default-parameter instance and a small-parameter
// instance share stimulus; the small one is tracked by a frame-level model.
module tb_vga_anim_sequencer;

  localparam int RMIN = 10, RMAX = 20, STEP = 4, HOLDF = 2, PAUSEF = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       vsync = 1'b1;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [9:0] o_scroll, o_radius, d_scroll, d_radius;
  logic [1:0] o_phase, o_palette, d_phase, d_palette;
  logic       o_tick, d_tick;
  logic [23:0] o_vec;

  int n_vec = 0;
  int n_err = 0;
  int m_scroll, m_radius, m_phase, m_pal, m_dwell, m_div;

  always #5 clk = ~clk;

  vga_anim_sequencer #(
    .VSYNC_ACTIVE_LOW(1), .RADIUS_MIN(RMIN), .RADIUS_MAX(RMAX),
    .RADIUS_STEP(STEP), .HOLD_FRAMES(HOLDF), .PAUSE_FRAMES(PAUSEF)
  ) u_ovr (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .step(step), .speed(speed),
    .scroll(o_scroll), .radius(o_radius), .phase(o_phase), .palette(o_palette),
    .frame_tick(o_tick)
  );

  vga_anim_sequencer u_def (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .step(step), .speed(speed),
    .scroll(d_scroll), .radius(d_radius), .phase(d_phase), .palette(d_palette),
    .frame_tick(d_tick)
  );

  assign o_vec = {o_scroll, o_radius, o_phase, o_palette};

  // Frame-level reference model of the small-parameter instance
  function automatic void m_reset();
    m_scroll = 0; m_radius = RMIN; m_phase = 0; m_pal = 0; m_dwell = 0; m_div = 0;
  endfunction

  function automatic void m_update();
    m_scroll = (m_scroll + 1) % 1024;
    case (m_phase)
      0: if (m_radius + STEP >= RMAX) begin m_radius = RMAX; m_phase = 1; m_dwell = 0; end
         else m_radius = m_radius + STEP;
      1: if (m_dwell == HOLDF - 1) begin m_phase = 2; m_dwell = 0; end
         else m_dwell++;
      2: if (m_radius <= RMIN + STEP) begin m_radius = RMIN; m_phase = 3; m_dwell = 0; end
         else m_radius = m_radius - STEP;
      default: if (m_dwell == PAUSEF - 1) begin m_phase = 0; m_dwell = 0; m_pal = (m_pal + 1) % 4; end
         else m_dwell++;
    endcase
  endfunction

  function automatic void m_frame();
    if (!pause) begin
      if (m_div >= (1 << speed) - 1) begin m_div = 0; m_update(); end
      else m_div++;
    end
  endfunction

  function automatic logic [23:0] exp_vec();
    return {10'(m_scroll), 10'(m_radius), 2'(m_phase), 2'(m_pal)};
  endfunction

  // Stimulus helpers: start and end just after a falling edge
  task automatic drive_frame();
    vsync = 1'b1; step = 1'b0;
    @(negedge clk);
    vsync = 1'b0;
    m_frame();
    @(negedge clk);
  endtask

  task automatic drive_step();
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    if (pause) m_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    vsync = 1'b0; pause = 1'b0; step = 1'b0; speed = 2'd0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({o_vec, o_tick} !== {10'd0, 10'd10, 2'd0, 2'd0, 1'b0}) begin
      n_err++; $display("FAIL reset_ovr got %h tick %b want 000,10,0,0 tick 0", o_vec, o_tick);
    end
    n_vec++;
    if ({d_scroll, d_radius, d_phase, d_palette, d_tick} !== {10'd0, 10'd40, 2'd0, 2'd0, 1'b0}) begin
      n_err++; $display("FAIL reset_def got s=%0d r=%0d want s=0 r=40", d_scroll, d_radius);
    end
    rst_n = 1'b1;
    m_reset();
    m_frame();
    @(negedge clk);
    n_vec++;
    if ({d_scroll, d_radius, d_phase, d_palette, d_tick} !== {10'd1, 10'd42, 2'd0, 2'd0, 1'b1}) begin
      n_err++; $display("FAIL first_frame_def got s=%0d r=%0d ph=%0d tick=%b want s=1 r=42 ph=0 tick=1",
                        d_scroll, d_radius, d_phase, d_tick);
    end
    n_vec++;
    if ({o_vec, o_tick} !== {exp_vec(), 1'b1}) begin
      n_err++; $display("FAIL first_frame_ovr got %h tick %b want %h tick 1", o_vec, o_tick, exp_vec());
    end
    @(negedge clk);
    n_vec++;
    if ({o_tick, d_tick} !== 2'b00) begin
      n_err++; $display("FAIL tick_width got %b want 00", {o_tick, d_tick});
    end
  endtask

  task automatic test_sequence();
    int er[8] = '{18, 20, 20, 20, 16, 12, 10, 10};
    int ep[8] = '{0, 1, 1, 2, 2, 2, 3, 0};
    for (int i = 0; i < 8; i++) begin
      drive_frame();
      n_vec++;
      if (o_radius !== 10'(er[i]) || o_phase !== 2'(ep[i])) begin
        n_err++; $display("FAIL seq_%0d got r=%0d ph=%0d want r=%0d ph=%0d", i, o_radius, o_phase, er[i], ep[i]);
      end
      n_vec++;
      if ({o_vec, o_tick} !== {exp_vec(), 1'b1}) begin
        n_err++; $display("FAIL seq_model_%0d got %h tick %b want %h", i, o_vec, o_tick, exp_vec());
      end
    end
    n_vec++;
    if (o_palette !== 2'd1) begin
      n_err++; $display("FAIL seq_palette got %0d want 1", o_palette);
    end
  endtask

  task automatic test_speed();
    int s0 = m_scroll;
    speed = 2'd2;
    repeat (8) drive_frame();
    n_vec++;
    if (o_scroll !== 10'(s0 + 2) || o_vec !== exp_vec()) begin
      n_err++; $display("FAIL speed2 got scroll=%0d want %0d", o_scroll, s0 + 2);
    end
    speed = 2'd3;
    repeat (5) drive_frame();
    n_vec++;
    if (o_scroll !== 10'(s0 + 2)) begin
      n_err++; $display("FAIL speed3_hold got scroll=%0d want %0d", o_scroll, s0 + 2);
    end
    speed = 2'd0;
    drive_frame();
    n_vec++;
    if (o_scroll !== 10'(s0 + 3) || o_vec !== exp_vec()) begin
      n_err++; $display("FAIL speed_drop got scroll=%0d want %0d", o_scroll, s0 + 3);
    end
  endtask

  task automatic test_pause_step();
    int s0 = m_scroll;
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_frame();
      n_vec++;
      if (o_scroll !== 10'(s0) || o_tick !== 1'b1) begin
        n_err++; $display("FAIL pause_frame_%0d got scroll=%0d tick=%b want %0d tick 1", i, o_scroll, o_tick, s0);
      end
    end
    repeat (3) drive_step();
    n_vec++;
    if (o_scroll !== 10'(s0 + 3) || o_vec !== exp_vec()) begin
      n_err++; $display("FAIL step3 got scroll=%0d want %0d", o_scroll, s0 + 3);
    end
    vsync = 1'b1; step = 1'b0;
    @(negedge clk);
    vsync = 1'b0; step = 1'b1;
    m_update();
    @(negedge clk);
    n_vec++;
    if (o_scroll !== 10'(s0 + 4) || o_vec !== exp_vec()) begin
      n_err++; $display("FAIL step_and_frame got scroll=%0d want %0d", o_scroll, s0 + 4);
    end
    pause = 1'b0;
    drive_step();
    n_vec++;
    if (o_scroll !== 10'(s0 + 4)) begin
      n_err++; $display("FAIL step_unpaused got scroll=%0d want %0d", o_scroll, s0 + 4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0, 1: pause = ~pause;
        2:    speed = 2'($urandom_range(0, 3));
        3, 4: drive_step();
        default: drive_frame();
      endcase
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      n_vec++;
      if (o_vec !== exp_vec()) begin
        n_err++; $display("FAIL random_%0d got %h want %h", i, o_vec, exp_vec());
      end
    end
    pause = 1'b0; speed = 2'd0; step = 1'b0;
  endtask

  task automatic test_wrap();
    vsync = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (1030) drive_frame();
    n_vec++;
    if (o_scroll !== 10'd6 || o_vec !== exp_vec()) begin
      n_err++; $display("FAIL wrap got scroll=%0d vec %h want 6 vec %h", o_scroll, o_vec, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 20 && m_phase != 2; i++) drive_frame();
    n_vec++;
    if (o_phase !== 2'd2) begin
      n_err++; $display("FAIL reach_shrink got phase=%0d want 2", o_phase);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_vec, o_tick} !== {10'd0, 10'd10, 2'd0, 2'd0, 1'b0} ||
        {d_scroll, d_radius, d_phase, d_palette, d_tick} !== {10'd0, 10'd40, 2'd0, 2'd0, 1'b0}) begin
      n_err++; $display("FAIL async_reset got ovr %h def s=%0d r=%0d ph=%0d want ovr 000,10,0,0 def 0,40,0",
                        o_vec, d_scroll, d_radius, d_phase);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_sequence();
    test_speed();
    test_pause_step();
    test_random();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
